// File: rtl/m68k_bus_target_pkg.sv
// Shared definitions for the 68000 bus target: FSM encoding, bus constants,
// default window base and the window decode helper.
package m68k_bus_target_pkg;

    // Default window base; it must be aligned to 2^(REG_AW+1) bytes.
    localparam logic [23:0] DEFAULT_BASE_ADDR = 24'hE90000;

    // Function code for CPU space (interrupt acknowledge and similar).
    // Cycles with this code are never answered.
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    // One-hot bus FSM encoding.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_DECODE = 6'b000010,
        ST_WAIT   = 6'b000100,
        ST_ACK    = 6'b001000,
        ST_HOLD   = 6'b010000,
        ST_IGNORE = 6'b100000
    } bus_state_e;

    // True when a byte address falls inside the window that starts at base
    // and spans 2^(aw+1) bytes.
    function automatic logic window_hit(input logic [23:0] addr,
                                        input logic [23:0] base,
                                        input int          aw);
        return (addr >> (aw + 1)) == (base >> (aw + 1));
    endfunction

endpackage

// File: rtl/m68k_bus_target_sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous bus inputs.
// RST_VAL sets the reset level so active-low strobes come up idle.
module m68k_bus_target_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    (* async_reg = "true" *) logic [W-1:0] meta_q;
    (* async_reg = "true" *) logic [W-1:0] sync_q;

    // Two-stage resynchronisation into the system clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: decodes an address window, answers with nDTACK after
// a programmable wait, and shares a 16-bit register bank with a local
// (Pi-side) single-cycle port so the bank works as a mailbox.
//
// state  | meaning
// IDLE   | waiting for synchronised AS low; snapshot address, FC, enable
// DECODE | window/FC check; waiting for a data strobe
// WAIT   | wait-state countdown; write merge on the first cycle
// ACK    | nDTACK driven (and data on reads) until AS rises
// HOLD   | one released cycle before accepting a new bus cycle
// IGNORE | cycle not for us; wait for AS to rise
module m68k_bus_target
    import m68k_bus_target_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          REG_AW      = 4,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic              sys_clk,
    input  logic              nRESET,
    input  logic [23:1]       A_IN,
    input  logic [15:0]       D_IN,
    output logic [15:0]       D_OUT,
    output logic              D_OE,
    input  logic              nAS_IN,
    input  logic              nUDS_IN,
    input  logic              nLDS_IN,
    input  logic              RnW_IN,
    input  logic [2:0]        FC_IN,
    output logic              nDTACK_OE,
    input  logic              enable,
    input  logic [REG_AW-1:0] loc_addr,
    input  logic [15:0]       loc_wdata,
    input  logic              loc_we,
    output logic [15:0]       loc_rdata,
    output logic              evt_write,
    output logic [REG_AW-1:0] evt_addr,
    output logic              loc_collision
);

    localparam int         DEPTH     = 1 << REG_AW;
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

    // Synchronised strobes and data.
    logic [3:0]  strb_s;
    logic [15:0] d_s;
    logic        as_n_s, uds_n_s, lds_n_s, rnw_s;

    m68k_bus_target_sync2 #(
        .W       (4),
        .RST_VAL (4'b1111)
    ) u_sync_strb (
        .clk_i  (sys_clk),
        .rst_ni (nRESET),
        .d_i    ({nAS_IN, nUDS_IN, nLDS_IN, RnW_IN}),
        .q_o    (strb_s)
    );

    m68k_bus_target_sync2 #(
        .W       (16),
        .RST_VAL (16'h0000)
    ) u_sync_data (
        .clk_i  (sys_clk),
        .rst_ni (nRESET),
        .d_i    (D_IN),
        .q_o    (d_s)
    );

    assign as_n_s  = strb_s[3];
    assign uds_n_s = strb_s[2];
    assign lds_n_s = strb_s[1];
    assign rnw_s   = strb_s[0];

    // FSM and cycle context.
    bus_state_e        state_q, state_d;
    logic [23:1]       addr_q, addr_d;
    logic [2:0]        fc_q, fc_d;
    logic              en_q, en_d;
    logic              rnw_q, rnw_d;
    logic              uds_q, uds_d;
    logic              lds_q, lds_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [15:0]       dout_q, dout_d;

    logic [15:0]       bank_q [DEPTH];
    logic [REG_AW-1:0] idx;
    logic              hit;
    logic              bus_we;
    logic              collision;
    logic [15:0]       merged;

    logic              evt_write_q;
    logic [REG_AW-1:0] evt_addr_q;
    logic              coll_q;
    logic [15:0]       loc_rdata_q;

    assign idx = addr_q[REG_AW:1];
    assign hit = en_q && (fc_q != FC_CPU_SPACE) &&
                 window_hit({addr_q, 1'b0}, BASE_ADDR, REG_AW);

    // Byte-lane merge of the synchronised bus data into the addressed word.
    assign merged = {uds_q ? d_s[15:8] : bank_q[idx][15:8],
                     lds_q ? d_s[7:0]  : bank_q[idx][7:0]};

    // A same-cycle local write to the word the bus is merging loses.
    assign collision = loc_we && bus_we && (loc_addr == idx);

    // Next-state and cycle-context logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fc_d    = fc_q;
        en_d    = en_q;
        rnw_d   = rnw_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        dout_d  = dout_q;
        bus_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!as_n_s) begin
                    state_d = ST_DECODE;
                    addr_d  = A_IN;
                    fc_d    = FC_IN;
                    en_d    = enable;
                    // Read data is snapshotted here so D_OUT has settled for
                    // the whole DECODE/WAIT stretch before nDTACK.
                    dout_d  = bank_q[A_IN[REG_AW:1]];
                end
            end
            ST_DECODE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end else if (!hit) begin
                    state_d = ST_IGNORE;
                end else if (!uds_n_s || !lds_n_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                    first_d = 1'b1;
                    rnw_d   = rnw_s;
                    uds_d   = !uds_n_s;
                    lds_d   = !lds_n_s;
                end
            end
            ST_WAIT: begin
                bus_we = first_q && !rnw_q;
                cnt_d  = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                // Leave as the counter reaches zero; WAIT lasts at least one
                // cycle so the write merge always has a slot.
                if (cnt_q <= 8'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (as_n_s) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            ST_IGNORE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and cycle-context registers.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            fc_q    <= '0;
            en_q    <= 1'b0;
            rnw_q   <= 1'b1;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fc_q    <= fc_d;
            en_q    <= en_d;
            rnw_q   <= rnw_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            dout_q  <= dout_d;
        end
    end

    // Register bank: bus merge has priority over the local port.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus_we && (idx == REG_AW'(i))) begin
                    bank_q[i] <= merged;
                end else if (loc_we && (loc_addr == REG_AW'(i))) begin
                    bank_q[i] <= loc_wdata;
                end
            end
        end
    end

    // Local read port and event/collision pulses.
    always_ff @(posedge sys_clk or negedge nRESET) begin
        if (!nRESET) begin
            evt_write_q <= 1'b0;
            evt_addr_q  <= '0;
            coll_q      <= 1'b0;
            loc_rdata_q <= '0;
        end else begin
            evt_write_q <= bus_we;
            if (bus_we) begin
                evt_addr_q <= idx;
            end
            coll_q      <= collision;
            loc_rdata_q <= bank_q[loc_addr];
        end
    end

    // Bus drivers decode straight from the state register so reset releases
    // them without waiting for a clock.
    assign nDTACK_OE     = (state_q == ST_ACK);
    assign D_OE          = (state_q == ST_ACK) && rnw_q;
    assign D_OUT         = dout_q;
    assign loc_rdata     = loc_rdata_q;
    assign evt_write     = evt_write_q;
    assign evt_addr      = evt_addr_q;
    assign loc_collision = coll_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Self-checking bench for m68k_bus_target with a word-array reference model.
module tb_m68k_bus_target;

    localparam int ACK_LAT  = 2 + 1 + 4 + 1;   // sync + decode + wait + ack
    localparam int MERGE_AT = ACK_LAT - 4;     // drive loc_we here -> sampled in first WAIT cycle

    logic        sys_clk = 1'b0;
    logic        nRESET;
    logic [23:1] A_IN;
    logic [15:0] D_IN;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        nAS_IN, nUDS_IN, nLDS_IN, RnW_IN;
    logic [2:0]  FC_IN;
    logic        nDTACK_OE;
    logic        enable;
    logic [3:0]  loc_addr;
    logic [15:0] loc_wdata;
    logic        loc_we;
    logic [15:0] loc_rdata;
    logic        evt_write;
    logic [3:0]  evt_addr;
    logic        loc_collision;

    m68k_bus_target dut (
        .sys_clk       (sys_clk),
        .nRESET        (nRESET),
        .A_IN          (A_IN),
        .D_IN          (D_IN),
        .D_OUT         (D_OUT),
        .D_OE          (D_OE),
        .nAS_IN        (nAS_IN),
        .nUDS_IN       (nUDS_IN),
        .nLDS_IN       (nLDS_IN),
        .RnW_IN        (RnW_IN),
        .FC_IN         (FC_IN),
        .nDTACK_OE     (nDTACK_OE),
        .enable        (enable),
        .loc_addr      (loc_addr),
        .loc_wdata     (loc_wdata),
        .loc_we        (loc_we),
        .loc_rdata     (loc_rdata),
        .evt_write     (evt_write),
        .evt_addr      (evt_addr),
        .loc_collision (loc_collision)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model [16];

    // Observations of the last bus cycle.
    int          obs_lat;
    logic [15:0] obs_rd;
    logic        obs_oe;
    int          obs_evt_n;
    logic [3:0]  obs_evt_a;
    int          obs_coll_n;
    logic        obs_stray;
    logic        obs_hold_ok;
    logic        obs_rel1;
    logic        obs_rel3;
    logic        obs_rel3_oe;

    task automatic bus_cycle(input logic [23:0] addr, input logic [2:0] fc,
                             input logic rnw, input logic uds, input logic lds,
                             input logic [15:0] wdata, input int budget,
                             input int hold, input int loc_at,
                             input logic [3:0] loc_a, input logic [15:0] loc_d);
        @(posedge sys_clk); #1;
        A_IN = addr[23:1]; FC_IN = fc; RnW_IN = rnw; D_IN = wdata;
        nAS_IN = 1'b0; nUDS_IN = !uds; nLDS_IN = !lds;
        obs_lat = -1; obs_rd = '0; obs_oe = 1'b0; obs_evt_n = 0; obs_evt_a = '0;
        obs_coll_n = 0; obs_stray = 1'b0; obs_hold_ok = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge sys_clk); #1;
            if (evt_write) begin obs_evt_n++; obs_evt_a = evt_addr; end
            if (loc_collision) obs_coll_n++;
            if (nDTACK_OE) begin
                obs_lat = n; obs_rd = D_OUT; obs_oe = D_OE;
                break;
            end
            if (D_OE) obs_stray = 1'b1;
            if (loc_at == n) begin
                loc_addr = loc_a; loc_wdata = loc_d; loc_we = 1'b1;
            end else begin
                loc_we = 1'b0;
            end
        end
        loc_we = 1'b0;
        if (obs_lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge sys_clk); #1;
                if (!nDTACK_OE) obs_hold_ok = 1'b0;
                if (evt_write) obs_evt_n++;
            end
        end
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1; RnW_IN = 1'b1;
        @(posedge sys_clk); #1;
        obs_rel1 = nDTACK_OE;
        if (evt_write) obs_evt_n++;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        obs_rel3 = nDTACK_OE; obs_rel3_oe = D_OE;
        if (obs_lat < 0 && (nDTACK_OE || D_OE)) obs_stray = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [15:0] d);
        @(posedge sys_clk); #1;
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        @(posedge sys_clk); #1;
        loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({D_OUT, D_OE, nDTACK_OE, loc_rdata, evt_write, evt_addr, loc_collision} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got D_OUT=%h D_OE=%b DTACK=%b rdata=%h evt=%b ea=%h coll=%b, expected all zero",
                     D_OUT, D_OE, nDTACK_OE, loc_rdata, evt_write, evt_addr, loc_collision);
        end
    endtask

    task automatic test_bank_dump(input string tag);
        for (int w = 0; w < 16; w++) begin
            @(posedge sys_clk); #1;
            loc_addr = 4'(w);
            @(posedge sys_clk); #1;
            n_cmp++;
            if (loc_rdata !== model[w]) begin
                n_err++;
                $display("FAIL %s_bank[%0d]: got %h expected %h", tag, w, loc_rdata, model[w]);
            end
        end
    endtask

    task automatic test_word_write;
        bus_cycle(24'hE90004, 3'b101, 1'b0, 1'b1, 1'b1, 16'hBEEF, 40, 0, -1, 4'h0, 16'h0);
        model[2] = 16'hBEEF;
        n_cmp++;
        if (obs_lat != ACK_LAT) begin n_err++; $display("FAIL write_latency: got %0d expected %0d", obs_lat, ACK_LAT); end
        n_cmp++;
        if (obs_evt_n != 1 || obs_evt_a !== 4'd2) begin
            n_err++; $display("FAIL write_event: got %0d pulses addr %0d expected 1 pulse addr 2", obs_evt_n, obs_evt_a);
        end
        @(posedge sys_clk); #1; loc_addr = 4'd2;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (loc_rdata !== 16'hBEEF) begin n_err++; $display("FAIL write_locread: got %h expected beef", loc_rdata); end
    endtask

    task automatic test_byte_read;
        bus_cycle(24'hE90005, 3'b101, 1'b1, 1'b0, 1'b1, 16'h0000, 40, 0, -1, 4'h0, 16'h0);
        n_cmp++;
        if (obs_lat != ACK_LAT) begin n_err++; $display("FAIL read_latency: got %0d expected %0d", obs_lat, ACK_LAT); end
        n_cmp++;
        if (obs_rd !== 16'hBEEF || obs_oe !== 1'b1) begin
            n_err++; $display("FAIL read_data: got %h oe=%b expected beef oe=1", obs_rd, obs_oe);
        end
        n_cmp++;
        if (obs_rel1 !== 1'b1 || obs_rel3 !== 1'b0 || obs_rel3_oe !== 1'b0) begin
            n_err++; $display("FAIL read_release: got +1=%b +3=%b oe=%b expected 1 0 0", obs_rel1, obs_rel3, obs_rel3_oe);
        end
    endtask

    task automatic test_miss;
        bus_cycle(24'hE80000, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0, 14, 0, -1, 4'h0, 16'h0);
        n_cmp++;
        if (obs_lat != -1 || obs_stray) begin n_err++; $display("FAIL miss_addr: got lat=%0d stray=%b expected none", obs_lat, obs_stray); end
        bus_cycle(24'hE90004, 3'b111, 1'b0, 1'b1, 1'b1, 16'h5555, 14, 0, -1, 4'h0, 16'h0);
        n_cmp++;
        if (obs_lat != -1 || obs_stray || obs_evt_n != 0) begin
            n_err++; $display("FAIL miss_cpuspace: got lat=%0d stray=%b evt=%0d expected none", obs_lat, obs_stray, obs_evt_n);
        end
        enable = 1'b0;
        bus_cycle(24'hE90004, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0, 14, 0, -1, 4'h0, 16'h0);
        enable = 1'b1;
        n_cmp++;
        if (obs_lat != -1 || obs_stray) begin n_err++; $display("FAIL miss_disabled: got lat=%0d stray=%b expected none", obs_lat, obs_stray); end
    endtask

    task automatic test_collision;
        bus_cycle(24'hE90006, 3'b001, 1'b0, 1'b1, 1'b1, 16'h1234, 40, 0, MERGE_AT, 4'd3, 16'h5678);
        model[3] = 16'h1234;
        n_cmp++;
        if (obs_coll_n != 1) begin n_err++; $display("FAIL coll_pulse: got %0d pulses expected 1", obs_coll_n); end
        bus_cycle(24'hE90008, 3'b001, 1'b0, 1'b1, 1'b1, 16'h4321, 40, 0, MERGE_AT, 4'd7, 16'h8765);
        model[4] = 16'h4321; model[7] = 16'h8765;
        n_cmp++;
        if (obs_coll_n != 0) begin n_err++; $display("FAIL coll_other_word: got %0d pulses expected 0", obs_coll_n); end
        test_bank_dump("coll");
    endtask

    task automatic test_long_as;
        bus_cycle(24'hE90006, 3'b010, 1'b1, 1'b1, 1'b1, 16'h0, 40, 100, -1, 4'h0, 16'h0);
        n_cmp++;
        if (obs_lat != ACK_LAT || !obs_hold_ok || obs_rd !== model[3]) begin
            n_err++; $display("FAIL long_as_hold: got lat=%0d held=%b data=%h expected %0d 1 %h", obs_lat, obs_hold_ok, obs_rd, ACK_LAT, model[3]);
        end
        n_cmp++;
        if (obs_rel1 !== 1'b1 || obs_rel3 !== 1'b0 || obs_rel3_oe !== 1'b0) begin
            n_err++; $display("FAIL long_as_release: got +1=%b +3=%b oe=%b expected 1 0 0", obs_rel1, obs_rel3, obs_rel3_oe);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  idx;
            logic [1:0]  lanes;
            logic [15:0] data;
            logic [23:0] addr;
            logic [2:0]  fc;
            logic        rnw, exp_ack;
            int          kind;
            idx   = 4'($urandom_range(0, 15));
            lanes = 2'($urandom_range(1, 3));
            data  = 16'($urandom);
            rnw   = 1'($urandom);
            kind  = $urandom_range(0, 9);
            fc    = 3'($urandom_range(0, 6));
            addr  = 24'hE90000 | {19'd0, idx, 1'b0};
            if (kind == 0) begin
                do addr[23:5] = 19'($urandom); while (addr[23:5] == 19'(24'hE90000 >> 5));
            end
            if (kind == 1) fc = 3'b111;
            enable  = (kind != 2);
            exp_ack = (kind >= 3);
            bus_cycle(addr, fc, rnw, lanes[1], lanes[0], data, exp_ack ? 40 : 14, 0, -1, 4'h0, 16'h0);
            enable = 1'b1;
            if (exp_ack) begin
                n_cmp++;
                if (obs_lat != ACK_LAT) begin n_err++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", t, obs_lat, ACK_LAT); end
                if (rnw) begin
                    n_cmp++;
                    if (obs_rd !== model[idx] || obs_oe !== 1'b1) begin
                        n_err++; $display("FAIL rand_read[%0d]: got %h oe=%b expected %h oe=1", t, obs_rd, obs_oe, model[idx]);
                    end
                end else begin
                    if (lanes[1]) model[idx][15:8] = data[15:8];
                    if (lanes[0]) model[idx][7:0]  = data[7:0];
                    n_cmp++;
                    if (obs_evt_n != 1 || obs_evt_a !== idx) begin
                        n_err++; $display("FAIL rand_event[%0d]: got %0d pulses addr %0d expected 1 addr %0d", t, obs_evt_n, obs_evt_a, idx);
                    end
                end
            end else begin
                n_cmp++;
                if (obs_lat != -1 || obs_stray || obs_evt_n != 0) begin
                    n_err++; $display("FAIL rand_miss[%0d]: got lat=%0d stray=%b evt=%0d expected none", t, obs_lat, obs_stray, obs_evt_n);
                end
            end
        end
        test_bank_dump("rand");
    endtask

    task automatic test_local_port;
        for (int k = 0; k < 8; k++) loc_write(4'($urandom_range(0, 15)), 16'($urandom));
        test_bank_dump("local");
    endtask

    task automatic test_reset_mid_ack;
        int waited = 0;
        @(posedge sys_clk); #1;
        A_IN = 24'hE90004 >> 1; FC_IN = 3'b101; RnW_IN = 1'b1; nAS_IN = 1'b0; nUDS_IN = 1'b0; nLDS_IN = 1'b0;
        while (!nDTACK_OE && waited < 40) begin @(posedge sys_clk); #1; waited++; end
        n_cmp++;
        if (!nDTACK_OE) begin n_err++; $display("FAIL rst_ack_timeout: got no ack within %0d cycles, expected ack", waited); end
        #3 nRESET = 1'b0;
        #1;
        n_cmp++;
        if (nDTACK_OE !== 1'b0 || D_OE !== 1'b0 || D_OUT !== 16'h0) begin
            n_err++; $display("FAIL rst_async_release: got DTACK=%b D_OE=%b D_OUT=%h expected 0 0 0000", nDTACK_OE, D_OE, D_OUT);
        end
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 nRESET = 1'b1;
        for (int w = 0; w < 16; w++) model[w] = 16'h0;
        test_bank_dump("rst");
    endtask

    initial begin
        nRESET = 1'b0; A_IN = '0; D_IN = '0; nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        RnW_IN = 1'b1; FC_IN = 3'b101; enable = 1'b1; loc_addr = '0; loc_wdata = '0; loc_we = 1'b0;
        for (int w = 0; w < 16; w++) model[w] = 16'h0;
        #23 nRESET = 1'b1;
        @(posedge sys_clk); #1;
        test_reset();
        test_word_write();
        test_byte_read();
        test_miss();
        test_collision();
        test_long_as();
        test_local_port();
        test_random();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
